// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between two requesters, with independent
// round-robin read and write arbitration, each grant held for a whole transaction.
module mem_port_arbiter #(
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_ar_valid,
    input  logic [ADDR_WDTH-1:0] m0_ar_address,
    output logic                 m0_ar_ready,
    output logic                 m0_r_valid,
    output logic [DATA_WDTH-1:0] m0_r_data,
    output logic [RESP_WDTH-1:0] m0_r_resp,
    input  logic                 m0_r_ready,
    input  logic                 m0_aw_valid,
    input  logic [ADDR_WDTH-1:0] m0_aw_address,
    output logic                 m0_aw_ready,
    input  logic                 m0_w_valid,
    input  logic [DATA_WDTH-1:0] m0_w_data,
    output logic                 m0_w_ready,
    output logic                 m0_b_valid,
    output logic [RESP_WDTH-1:0] m0_b_resp,
    input  logic                 m0_b_ready,
    input  logic                 m1_ar_valid,
    input  logic [ADDR_WDTH-1:0] m1_ar_address,
    output logic                 m1_ar_ready,
    output logic                 m1_r_valid,
    output logic [DATA_WDTH-1:0] m1_r_data,
    output logic [RESP_WDTH-1:0] m1_r_resp,
    input  logic                 m1_r_ready,
    input  logic                 m1_aw_valid,
    input  logic [ADDR_WDTH-1:0] m1_aw_address,
    output logic                 m1_aw_ready,
    input  logic                 m1_w_valid,
    input  logic [DATA_WDTH-1:0] m1_w_data,
    output logic                 m1_w_ready,
    output logic                 m1_b_valid,
    output logic [RESP_WDTH-1:0] m1_b_resp,
    input  logic                 m1_b_ready,
    output logic                 s_ar_valid,
    output logic [ADDR_WDTH-1:0] s_ar_address,
    input  logic                 s_ar_ready,
    input  logic                 s_r_valid,
    input  logic [DATA_WDTH-1:0] s_r_data,
    input  logic [RESP_WDTH-1:0] s_r_resp,
    output logic                 s_r_ready,
    output logic                 s_aw_valid,
    output logic [ADDR_WDTH-1:0] s_aw_address,
    input  logic                 s_aw_ready,
    output logic                 s_w_valid,
    output logic [DATA_WDTH-1:0] s_w_data,
    input  logic                 s_w_ready,
    input  logic                 s_b_valid,
    input  logic [RESP_WDTH-1:0] s_b_resp,
    output logic                 s_b_ready,
    output logic [1:0]           rd_grant,
    output logic [1:0]           wr_grant
);
    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_XFER, WR_RESP} wr_state_t;
    rd_state_t rd_state, rd_state_n;
    wr_state_t wr_state, wr_state_n;
    logic rd_owner, rd_owner_n, rd_last, rd_last_n;
    logic wr_owner, wr_owner_n, wr_last, wr_last_n;
    logic aw_done, aw_done_n, w_done, w_done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            wr_state <= WR_IDLE;
            rd_owner <= 1'b0;
            wr_owner <= 1'b0;
            rd_last  <= 1'b1;
            wr_last  <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            rd_state <= rd_state_n;
            wr_state <= wr_state_n;
            rd_owner <= rd_owner_n;
            wr_owner <= wr_owner_n;
            rd_last  <= rd_last_n;
            wr_last  <= wr_last_n;
            aw_done  <= aw_done_n;
            w_done   <= w_done_n;
        end
    end

    // Owner 1 wins only when m0 is absent or m0 was the last one served.
    always_comb begin
        rd_state_n   = rd_state;
        rd_owner_n   = rd_owner;
        rd_last_n    = rd_last;
        rd_grant     = 2'b00;
        s_ar_valid   = 1'b0;
        s_ar_address = '0;
        s_r_ready    = 1'b0;
        m0_ar_ready  = 1'b0;
        m1_ar_ready  = 1'b0;
        m0_r_valid   = 1'b0;
        m1_r_valid   = 1'b0;
        m0_r_data    = '0;
        m1_r_data    = '0;
        m0_r_resp    = '0;
        m1_r_resp    = '0;
        case (rd_state)
            RD_IDLE: begin
                if (m0_ar_valid || m1_ar_valid) begin
                    rd_owner_n = m1_ar_valid && (!m0_ar_valid || !rd_last);
                    rd_state_n = RD_ADDR;
                end
            end
            RD_ADDR: begin
                rd_grant     = rd_owner ? 2'b10 : 2'b01;
                s_ar_valid   = rd_owner ? m1_ar_valid : m0_ar_valid;
                s_ar_address = rd_owner ? m1_ar_address : m0_ar_address;
                m0_ar_ready  = !rd_owner && s_ar_ready;
                m1_ar_ready  = rd_owner && s_ar_ready;
                if (s_ar_valid && s_ar_ready) rd_state_n = RD_DATA;
            end
            RD_DATA: begin
                rd_grant   = rd_owner ? 2'b10 : 2'b01;
                s_r_ready  = rd_owner ? m1_r_ready : m0_r_ready;
                m0_r_valid = !rd_owner && s_r_valid;
                m1_r_valid = rd_owner && s_r_valid;
                m0_r_data  = rd_owner ? '0 : s_r_data;
                m1_r_data  = rd_owner ? s_r_data : '0;
                m0_r_resp  = rd_owner ? '0 : s_r_resp;
                m1_r_resp  = rd_owner ? s_r_resp : '0;
                if (s_r_valid && s_r_ready) begin
                    rd_last_n  = rd_owner;
                    rd_state_n = RD_IDLE;
                end
            end
            default: rd_state_n = RD_IDLE;
        endcase
    end

    // aw and w complete in any order; a finished channel is masked until the response.
    always_comb begin
        wr_state_n   = wr_state;
        wr_owner_n   = wr_owner;
        wr_last_n    = wr_last;
        aw_done_n    = aw_done;
        w_done_n     = w_done;
        wr_grant     = 2'b00;
        s_aw_valid   = 1'b0;
        s_aw_address = '0;
        s_w_valid    = 1'b0;
        s_w_data     = '0;
        s_b_ready    = 1'b0;
        m0_aw_ready  = 1'b0;
        m1_aw_ready  = 1'b0;
        m0_w_ready   = 1'b0;
        m1_w_ready   = 1'b0;
        m0_b_valid   = 1'b0;
        m1_b_valid   = 1'b0;
        m0_b_resp    = '0;
        m1_b_resp    = '0;
        case (wr_state)
            WR_IDLE: begin
                if (m0_aw_valid || m1_aw_valid) begin
                    wr_owner_n = m1_aw_valid && (!m0_aw_valid || !wr_last);
                    wr_state_n = WR_XFER;
                end
            end
            WR_XFER: begin
                wr_grant     = wr_owner ? 2'b10 : 2'b01;
                s_aw_valid   = !aw_done && (wr_owner ? m1_aw_valid : m0_aw_valid);
                s_aw_address = aw_done ? '0 : (wr_owner ? m1_aw_address : m0_aw_address);
                s_w_valid    = !w_done && (wr_owner ? m1_w_valid : m0_w_valid);
                s_w_data     = w_done ? '0 : (wr_owner ? m1_w_data : m0_w_data);
                m0_aw_ready  = !wr_owner && !aw_done && s_aw_ready;
                m1_aw_ready  = wr_owner && !aw_done && s_aw_ready;
                m0_w_ready   = !wr_owner && !w_done && s_w_ready;
                m1_w_ready   = wr_owner && !w_done && s_w_ready;
                aw_done_n    = aw_done || (s_aw_valid && s_aw_ready);
                w_done_n     = w_done || (s_w_valid && s_w_ready);
                if (aw_done_n && w_done_n) wr_state_n = WR_RESP;
            end
            WR_RESP: begin
                wr_grant   = wr_owner ? 2'b10 : 2'b01;
                s_b_ready  = wr_owner ? m1_b_ready : m0_b_ready;
                m0_b_valid = !wr_owner && s_b_valid;
                m1_b_valid = wr_owner && s_b_valid;
                m0_b_resp  = wr_owner ? '0 : s_b_resp;
                m1_b_resp  = wr_owner ? s_b_resp : '0;
                if (s_b_valid && s_b_ready) begin
                    aw_done_n  = 1'b0;
                    w_done_n   = 1'b0;
                    wr_last_n  = wr_owner;
                    wr_state_n = WR_IDLE;
                end
            end
            default: wr_state_n = WR_IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors; the bench plays both requesters and the memory.
module tb_mem_port_arbiter;
    logic clk = 1'b0, rst;
    logic m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_ready, m0_aw_valid, m0_aw_ready;
    logic m0_w_valid, m0_w_ready, m0_b_valid, m0_b_ready;
    logic m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_ready, m1_aw_valid, m1_aw_ready;
    logic m1_w_valid, m1_w_ready, m1_b_valid, m1_b_ready;
    logic [3:0] m0_ar_address, m0_aw_address, m1_ar_address, m1_aw_address;
    logic [31:0] m0_r_data, m0_w_data, m1_r_data, m1_w_data;
    logic m0_r_resp, m0_b_resp, m1_r_resp, m1_b_resp;
    logic s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_aw_valid, s_aw_ready;
    logic s_w_valid, s_w_ready, s_b_valid, s_b_ready, s_r_resp, s_b_resp;
    logic [3:0] s_ar_address, s_aw_address;
    logic [31:0] s_r_data, s_w_data;
    logic [1:0] rd_grant, wr_grant;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_ar_valid(m0_ar_valid), .m0_ar_address(m0_ar_address), .m0_ar_ready(m0_ar_ready),
        .m0_r_valid(m0_r_valid), .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp), .m0_r_ready(m0_r_ready),
        .m0_aw_valid(m0_aw_valid), .m0_aw_address(m0_aw_address), .m0_aw_ready(m0_aw_ready),
        .m0_w_valid(m0_w_valid), .m0_w_data(m0_w_data), .m0_w_ready(m0_w_ready),
        .m0_b_valid(m0_b_valid), .m0_b_resp(m0_b_resp), .m0_b_ready(m0_b_ready),
        .m1_ar_valid(m1_ar_valid), .m1_ar_address(m1_ar_address), .m1_ar_ready(m1_ar_ready),
        .m1_r_valid(m1_r_valid), .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp), .m1_r_ready(m1_r_ready),
        .m1_aw_valid(m1_aw_valid), .m1_aw_address(m1_aw_address), .m1_aw_ready(m1_aw_ready),
        .m1_w_valid(m1_w_valid), .m1_w_data(m1_w_data), .m1_w_ready(m1_w_ready),
        .m1_b_valid(m1_b_valid), .m1_b_resp(m1_b_resp), .m1_b_ready(m1_b_ready),
        .s_ar_valid(s_ar_valid), .s_ar_address(s_ar_address), .s_ar_ready(s_ar_ready),
        .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_ready(s_r_ready),
        .s_aw_valid(s_aw_valid), .s_aw_address(s_aw_address), .s_aw_ready(s_aw_ready),
        .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_ready(s_w_ready),
        .s_b_valid(s_b_valid), .s_b_resp(s_b_resp), .s_b_ready(s_b_ready),
        .rd_grant(rd_grant), .wr_grant(wr_grant)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        {m0_ar_valid, m0_r_ready, m0_aw_valid, m0_w_valid, m0_b_ready} = '0;
        {m1_ar_valid, m1_r_ready, m1_aw_valid, m1_w_valid, m1_b_ready} = '0;
        {m0_ar_address, m0_aw_address, m1_ar_address, m1_aw_address} = '0;
        {m0_w_data, m1_w_data, s_r_data} = '0;
        {s_ar_ready, s_r_valid, s_r_resp, s_aw_ready, s_w_ready, s_b_valid, s_b_resp} = '0;
    endtask

    // Leaves the bench at a negedge with rst low and the DUT in reset state.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    // All 15 valid/ready outputs packed together.
    function automatic logic [14:0] vr();
        return {m0_ar_ready, m0_r_valid, m0_aw_ready, m0_w_ready, m0_b_valid,
                m1_ar_ready, m1_r_valid, m1_aw_ready, m1_w_ready, m1_b_valid,
                s_ar_valid, s_r_ready, s_aw_valid, s_w_valid, s_b_ready};
    endfunction

    initial begin
        clear_inputs();
        rst = 1'b1;
        do_reset();
        #1;
        chk("rst_vr", 32'(vr()), 0);
        chk("rst_grants", {rd_grant, wr_grant}, 0);
        chk("rst_data", m0_r_data | m1_r_data | s_w_data, 0);

        // 1: single read by m0
        m0_ar_valid = 1; m0_ar_address = 4'h3; s_ar_ready = 1; m0_r_ready = 1;
        #1 chk("t1_idle_grant", rd_grant, 2'b00);
        chk("t1_idle_arv", s_ar_valid, 0);
        nxt(); #1;
        chk("t1_grant_a", rd_grant, 2'b01);
        chk("t1_arv", s_ar_valid, 1);
        chk("t1_addr", s_ar_address, 4'h3);
        chk("t1_m0_arr", m0_ar_ready, 1);
        chk("t1_m1_arr", m1_ar_ready, 0);
        nxt(); m0_ar_valid = 0; #1;
        chk("t1_arv_drop", s_ar_valid, 0);
        chk("t1_rready", s_r_ready, 1);
        chk("t1_rv_early", m0_r_valid, 0);
        nxt(); nxt(); s_r_valid = 1; s_r_data = 32'hDEADBEEF; s_r_resp = 0; #1;
        chk("t1_grant_d", rd_grant, 2'b01);
        chk("t1_rv", m0_r_valid, 1);
        chk("t1_rdata", m0_r_data, 32'hDEADBEEF);
        chk("t1_m1_vr", {m1_ar_ready, m1_r_valid, m1_aw_ready, m1_w_ready, m1_b_valid}, 0);
        chk("t1_m1_data", m1_r_data, 0);
        nxt(); s_r_valid = 0; #1;
        chk("t1_end_grant", rd_grant, 2'b00);
        chk("t1_end_data", m0_r_data, 0);

        // 2: read contention, alternation
        do_reset();
        m0_ar_valid = 1; m0_ar_address = 4'h1; m1_ar_valid = 1; m1_ar_address = 4'h2;
        s_ar_ready = 1; m0_r_ready = 1; m1_r_ready = 1;
        nxt(); #1;
        chk("t2_first_grant", rd_grant, 2'b01);
        chk("t2_first_addr", s_ar_address, 4'h1);
        chk("t2_m1_wait", m1_ar_ready, 0);
        nxt(); m0_ar_valid = 0; s_r_valid = 1; s_r_data = 32'h11; #1;
        chk("t2_m0_data", m0_r_data, 32'h11);
        chk("t2_m1_rv", m1_r_valid, 0);
        nxt(); s_r_valid = 0; #1;
        chk("t2_gap_grant", rd_grant, 2'b00);
        nxt(); #1;
        chk("t2_second_grant", rd_grant, 2'b10);
        chk("t2_second_addr", s_ar_address, 4'h2);
        chk("t2_m1_arr", m1_ar_ready, 1);
        chk("t2_m0_arr", m0_ar_ready, 0);
        nxt(); m1_ar_valid = 0; s_r_valid = 1; s_r_data = 32'h22; #1;
        chk("t2_m1_data", m1_r_data, 32'h22);
        chk("t2_m0_data0", m0_r_data, 0);
        nxt(); s_r_valid = 0;
        m0_ar_valid = 1; m0_ar_address = 4'h1; m1_ar_valid = 1; m1_ar_address = 4'h2; #1;
        chk("t2_gap2_grant", rd_grant, 2'b00);
        nxt(); #1;
        chk("t2_alt_grant", rd_grant, 2'b01);

        // 3: m1 write, aw accepted before w
        do_reset();
        m1_aw_valid = 1; m1_aw_address = 4'h7; m1_w_valid = 1; m1_w_data = 32'h55;
        s_aw_ready = 1; m1_b_ready = 1; #1;
        chk("t3_idle_grant", wr_grant, 2'b00);
        nxt(); #1;
        chk("t3_grant", wr_grant, 2'b10);
        chk("t3_awv", s_aw_valid, 1);
        chk("t3_awaddr", s_aw_address, 4'h7);
        chk("t3_m1_awr", m1_aw_ready, 1);
        chk("t3_wdata", s_w_data, 32'h55);
        chk("t3_m1_wr0", m1_w_ready, 0);
        for (int i = 0; i < 2; i++) begin
            nxt(); #1;
            chk("t3_awv_masked", s_aw_valid, 0);
            chk("t3_awr_masked", m1_aw_ready, 0);
            chk("t3_wv_hold", s_w_valid, 1);
        end
        nxt(); s_w_ready = 1; #1;
        chk("t3_m1_wr", m1_w_ready, 1);
        chk("t3_wdata2", s_w_data, 32'h55);
        nxt(); m1_aw_valid = 0; m1_w_valid = 0; s_w_ready = 0; s_b_valid = 1; s_b_resp = 1; #1;
        chk("t3_bv", m1_b_valid, 1);
        chk("t3_bresp", m1_b_resp, 1);
        chk("t3_bready", s_b_ready, 1);
        chk("t3_m0_bv", m0_b_valid, 0);
        nxt(); s_b_valid = 0; #1;
        chk("t3_end_grant", wr_grant, 2'b00);

        // 4: m0 reads while m1 writes
        do_reset();
        m0_ar_valid = 1; m0_ar_address = 4'h5; m1_aw_valid = 1; m1_aw_address = 4'h5;
        m1_w_valid = 1; m1_w_data = 32'hA5; s_ar_ready = 1; s_aw_ready = 1; s_w_ready = 1;
        m0_r_ready = 1; m1_b_ready = 1;
        nxt(); #1;
        chk("t4_grants", {rd_grant, wr_grant}, 4'b0110);
        chk("t4_araddr", s_ar_address, 4'h5);
        chk("t4_awaddr", s_aw_address, 4'h5);
        chk("t4_cross_rdy", {m0_aw_ready, m0_w_ready, m1_ar_ready}, 0);
        nxt(); clear_inputs(); m0_r_ready = 1; m1_b_ready = 1;
        s_r_valid = 1; s_r_data = 32'h12345678; s_r_resp = 1; s_b_valid = 1; s_b_resp = 1; #1;
        chk("t4_grants2", {rd_grant, wr_grant}, 4'b0110);
        chk("t4_m0_r", {m0_r_valid, m0_r_resp}, 2'b11);
        chk("t4_m0_rdata", m0_r_data, 32'h12345678);
        chk("t4_m1_r", {m1_r_valid, m1_r_resp}, 0);
        chk("t4_m1_rdata", m1_r_data, 0);
        chk("t4_m1_b", {m1_b_valid, m1_b_resp}, 2'b11);
        chk("t4_m0_b", {m0_b_valid, m0_b_resp}, 0);
        nxt(); s_r_valid = 0; s_b_valid = 0; #1;
        chk("t4_end_grants", {rd_grant, wr_grant}, 0);

        // 5: read data backpressure
        do_reset();
        m0_ar_valid = 1; m0_ar_address = 4'h9; s_ar_ready = 1;
        nxt(); #1;
        chk("t5_addr", s_ar_address, 4'h9);
        nxt(); m0_ar_valid = 0; s_r_valid = 1; s_r_data = 32'hCAFE0001;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nxt();
            #1;
            chk("t5_rready_low", s_r_ready, 0);
            chk("t5_rv_hold", m0_r_valid, 1);
            chk("t5_data_hold", m0_r_data, 32'hCAFE0001);
            chk("t5_grant_hold", rd_grant, 2'b01);
        end
        nxt(); m0_r_ready = 1; #1;
        chk("t5_rready", s_r_ready, 1);
        nxt(); #1;
        chk("t5_once_rv", m0_r_valid, 0);
        chk("t5_once_rready", s_r_ready, 0);
        chk("t5_end_grant", rd_grant, 2'b00);

        // 6: reset in the middle of a write with aw already done
        do_reset();
        m1_aw_valid = 1; m1_aw_address = 4'h3; m1_w_valid = 1; m1_w_data = 32'h77;
        s_aw_ready = 1; m1_b_ready = 1;
        nxt(); nxt(); #1;
        chk("t6_aw_done", s_aw_valid, 0);
        chk("t6_wv", s_w_valid, 1);
        rst = 1;
        nxt(); rst = 0; #1;
        chk("t6_rst_vr", 32'(vr()), 0);
        chk("t6_rst_grant", wr_grant, 2'b00);
        s_w_ready = 1;
        nxt(); #1;
        chk("t6_regrant", wr_grant, 2'b10);
        chk("t6_awv_again", s_aw_valid, 1);
        chk("t6_wv_again", s_w_valid, 1);
        nxt(); m1_aw_valid = 0; m1_w_valid = 0; s_aw_ready = 0; s_w_ready = 0;
        s_b_valid = 1; s_b_resp = 0; #1;
        chk("t6_bv", m1_b_valid, 1);
        nxt(); s_b_valid = 0; #1;
        chk("t6_end_grant", wr_grant, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
